display_list_buffer: RTL and testbench

- Double-buffered (ping-pong) display-list memory that takes the place of the fixed vector ROM upstream of top_vector_display.
- A producer (game/overlay logic) streams 18-bit vector entries into the back bank over a valid/ready handshake, then commits the list.
- The display reads the front bank through an asynchronous-read addr/data port with the same timing as the ROM.
- Banks swap only at a frame boundary, signalled by frame_drawn, so the display never draws a half-written list.

---
 rtl/display_list_buffer_if.sv | 13 +
 rtl/display_list_buffer.sv | 90 +++++++++
 tb/tb_display_list_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_list_buffer_if.sv
// Producer-side write channel of the display list buffer: valid/ready handshake
// carrying one vector entry plus the list-commit flag.
interface display_list_buffer_if #(
  parameter int DATAWIDTH = 18
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [DATAWIDTH-1:0] wr_data;
  logic                 wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/display_list_buffer.sv
// Ping-pong display-list memory: the producer fills the back bank, the display
// reads the front bank with ROM timing, and banks swap only on frame_drawn.
module display_list_buffer #(
    parameter int                   ADDRESSWIDTH = 8,
    parameter int                   DATAWIDTH    = 18,
    parameter logic [DATAWIDTH-1:0] EMPTY_WORD   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    display_list_buffer_if.slave    wr,
    input  logic                    frame_drawn,
    input  logic [ADDRESSWIDTH-1:0] addr,
    output logic [DATAWIDTH-1:0]    data_out,
    output logic [ADDRESSWIDTH:0]   front_count,
    output logic                    swap_done,
    output logic                    overflow
);

    localparam int DEPTH = 2 ** ADDRESSWIDTH;

    typedef enum logic {FILL, PENDING} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    bank_sel;
    logic [ADDRESSWIDTH-1:0] wr_ptr;
    logic [ADDRESSWIDTH:0]   back_count;
    logic                    accept;
    logic                    commit;
    logic                    swap;

    // Both banks live in one array; the MSB of the index is the bank select.
    logic [DATAWIDTH-1:0] mem [0:2*DEPTH-1];

    always_comb begin
        state_next  = state;
        wr.wr_ready = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        swap        = 1'b0;
        case (state)
            FILL: begin
                wr.wr_ready = 1'b1;
                accept      = wr.wr_valid;
                commit      = accept && (wr.wr_last || (wr_ptr == '1));
                if (commit) state_next = PENDING;
            end
            PENDING: begin
                swap = frame_drawn;
                if (swap) state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            bank_sel    <= 1'b0;
            wr_ptr      <= '0;
            back_count  <= '0;
            front_count <= '0;
            swap_done   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state     <= state_next;
            swap_done <= swap;
            if (accept) wr_ptr <= wr_ptr + ADDRESSWIDTH'(1);
            if (commit) begin
                back_count <= {1'b0, wr_ptr} + (ADDRESSWIDTH+1)'(1);
                // A commit without wr_last can only come from filling the last slot.
                if (!wr.wr_last) overflow <= 1'b1;
            end
            if (swap) begin
                bank_sel    <= ~bank_sel;
                front_count <= back_count;
                wr_ptr      <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[{~bank_sel, wr_ptr}] <= wr.wr_data;
    end

    always_comb begin
        data_out = EMPTY_WORD;
        if ({1'b0, addr} < front_count) data_out = mem[{bank_sel, addr}];
    end

endmodule

// File: tb/tb_display_list_buffer.sv
// Directed + random bench for display_list_buffer against a queue-based model
// of the front list, back list and commit/swap rules.
module tb_display_list_buffer;

    localparam int          AW    = 8;
    localparam int          DW    = 18;
    localparam int          DEPTH = 256;
    localparam logic [DW-1:0] EMPTY = 18'h3F000;

    logic          clk;
    logic          rst;
    logic          frame_drawn;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_out;
    logic [AW:0]   front_count;
    logic          swap_done;
    logic          overflow;

    display_list_buffer_if #(.DATAWIDTH(DW)) bus ();

    display_list_buffer #(
        .ADDRESSWIDTH(AW),
        .DATAWIDTH   (DW),
        .EMPTY_WORD  (EMPTY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (bus.slave),
        .frame_drawn(frame_drawn),
        .addr       (addr),
        .data_out   (data_out),
        .front_count(front_count),
        .swap_done  (swap_done),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [DW-1:0] m_front[$];
    logic [DW-1:0] m_back[$];
    bit            m_pending = 1'b0;
    bit            m_swap    = 1'b0;
    bit            m_ovf     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input int a);
        if (a < m_front.size()) return m_front[a];
        return EMPTY;
    endfunction

    task automatic check_outputs();
        chk("wr_ready", {31'b0, bus.wr_ready}, {31'b0, !m_pending});
        chk("swap_done", {31'b0, swap_done}, {31'b0, m_swap});
        chk("front_count", {23'b0, front_count}, m_front.size());
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        addr = AW'($urandom_range(0, DEPTH - 1));
        #1;
        chk("data_out_rand", {14'b0, data_out}, {14'b0, exp_read(int'(addr))});
    endtask

    task automatic sweep();
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            chk("data_out_sweep", {14'b0, data_out}, {14'b0, exp_read(a)});
        end
    endtask

    // One clock: update the model from the inputs present at the edge, then check.
    task automatic tick();
        if (m_pending) begin
            m_swap = frame_drawn;
            if (frame_drawn) begin
                m_front   = m_back;
                m_back    = {};
                m_pending = 1'b0;
            end
        end else begin
            m_swap = 1'b0;
            if (bus.wr_valid) begin
                m_back.push_back(bus.wr_data);
                if (bus.wr_last || m_back.size() == DEPTH) begin
                    if (!bus.wr_last) m_ovf = 1'b1;
                    m_pending = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic push(input logic [DW-1:0] d, input bit last, input bit fd);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_last  = last;
        frame_drawn  = fd;
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        frame_drawn  = 1'b0;
    endtask

    task automatic idle(input bit fd);
        bus.wr_valid = 1'b0;
        frame_drawn  = fd;
        tick();
        frame_drawn  = 1'b0;
    endtask

    task automatic write_list(input int n, input bit use_last, input bit fd_noise);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle(fd_noise && $urandom_range(0, 1) == 1);
            push(DW'($urandom), use_last && (i == n - 1), fd_noise && $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic mid_reset();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        frame_drawn  = 1'b0;
        #200;
        rst = 1'b1;
        #1;
        m_front   = {};
        m_back    = {};
        m_pending = 1'b0;
        m_swap    = 1'b0;
        m_ovf     = 1'b0;
        check_outputs();
        sweep();
        #10;
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        frame_drawn  = 1'b0;
        addr         = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_last  = 1'b0;

        // Reset state
        #1;
        check_outputs();
        sweep();
        #20;
        rst = 1'b0;

        // Three fixed entries, swap five idle cycles after commit
        push(18'h00101, 1'b0, 1'b0);
        push(18'h00202, 1'b0, 1'b0);
        push(18'h3FFFF, 1'b1, 1'b0);
        repeat (5) idle(1'b0);
        idle(1'b1);
        sweep();
        idle(1'b0);

        // List A, then list B filled while frame_drawn pulses
        write_list(2, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        write_list(4, 1'b1, 1'b1);
        repeat (2) idle(1'b0);
        idle(1'b1);
        sweep();

        // Commit coincident with frame_drawn; producer keeps pushing in PENDING
        push(DW'($urandom), 1'b0, 1'b0);
        push(DW'($urandom), 1'b1, 1'b1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = DW'($urandom);
        repeat (4) tick();
        frame_drawn = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        frame_drawn  = 1'b0;
        tick();
        sweep();

        // frame_drawn held across the commit cycle and the next one
        push(DW'($urandom), 1'b0, 1'b0);
        push(DW'($urandom), 1'b1, 1'b1);
        frame_drawn = 1'b1;
        tick();
        frame_drawn = 1'b0;
        tick();
        sweep();

        // Full-depth stream without wr_last
        write_list(DEPTH, 1'b0, 1'b1);
        repeat (2) idle(1'b0);
        idle(1'b1);
        sweep();
        write_list(3, 1'b1, 1'b0);
        idle(1'b1);
        sweep();

        // Reset while PENDING, then reset mid-fill
        write_list(3, 1'b1, 1'b0);
        mid_reset();
        idle(1'b1);
        idle(1'b0);
        write_list(2, 1'b0, 1'b0);
        mid_reset();
        idle(1'b1);
        idle(1'b0);
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
